camera_product_filter: RTL and testbench
========================================

# camera_product_filter

Sequential, parametrised successor to the combinational camera decoder in the supermarket scale project. It qualifies the raw product code from the camera. A code counts as detected only after it has been stable for a set number of clock samples. It is released only after it has been absent for a set number of samples. Single-cycle detect and remove events go to the scale/price controller.

## Interface
Parameters:
- `CODE_W`, 3: width of the camera product code; code 0 means "no product".
- `STABLE_CYCLES`, 4: consecutive identical non-zero samples required to lock a code (≥1).
- `RELEASE_CYCLES`, 3: consecutive non-matching samples required to release a locked code (≥1).

Ports:
- `clk`  in  1: system clock, rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `camera_output`  in  CODE_W: raw code from the camera.
- `product_detected`  out  CODE_W: locked product code; 0 when none.
- `product_valid`  out  1: high while a code is locked.
- `new_product`  out  1: one-cycle pulse when a code becomes locked.
- `product_removed`  out  1: one-cycle pulse when a locked code is released.

## Operation
- States:
  - `IDLE`: nothing held.
  - `CANDIDATE`: a code is being qualified.
  - `LOCKED`: a code is held.
- Internal registers:
  - `cand`: CODE_W bits.
  - `stab_cnt`: $clog2(STABLE_CYCLES+1) bits.
  - `rel_cnt`: $clog2(RELEASE_CYCLES+1) bits.
- IDLE:
  - Sample 0: stay.
  - Sample non-zero X: go to CANDIDATE with cand=X, stab_cnt=1.
  - If STABLE_CYCLES==1, go directly to LOCKED instead.
- CANDIDATE:
  - Sample == cand: stab_cnt+1. When stab_cnt reaches STABLE_CYCLES, go to LOCKED.
  - Sample non-zero and ≠ cand: restart with cand=sample, stab_cnt=1.
  - Sample 0: go to IDLE and clear counters.
- Entering LOCKED:
  - product_detected=cand, product_valid=1.
  - new_product=1 for exactly that one cycle.
  - rel_cnt=0.
- LOCKED:
  - Sample == product_detected: rel_cnt=0.
  - Any other sample (0 or a different code): rel_cnt+1.
  - When rel_cnt reaches RELEASE_CYCLES: product_removed=1 for one cycle, product_detected=0, product_valid=0, go to IDLE.
  - A different code never swaps the lock directly. It must first release, then qualify again from IDLE.
- Counters saturate at their terminal value; they never wrap.
- new_product and product_removed are never high in the same cycle.

## Timing
- Reset values: state=IDLE; all outputs 0; cand, stab_cnt and rel_cnt all 0.
- Reset is effective immediately, including mid-qualification and mid-lock. No removal pulse is issued on reset.
- camera_output is sampled on each rising clk.
- Lock latency without CAMERA_SYNC_EN:
  - A code first sampled at edge k is locked at edge k+STABLE_CYCLES−1.
  - Outputs are registered and valid after that edge.
- Release latency: the first non-matching sample at edge m releases at edge m+RELEASE_CYCLES−1.
- All outputs are registered; there are no combinational paths from input to output.

## Configuration
- `CAMERA_SYNC_EN` defined:
  - camera_output passes through a 2-flop synchroniser before the state machine.
  - Both flops reset to 0.
  - Lock and release latencies each grow by exactly 2 cycles.
- `CAMERA_SYNC_EN` undefined: camera_output feeds the state machine directly; latencies are as stated above.

## Structure
- The shared package holds:
  - the state encoding constants: IDLE=2'd0, CANDIDATE=2'd1, LOCKED=2'd2;
  - the `NO_PRODUCT` code constant (0).
- The scale controller reuses these same constants.
- One sub-module is natural: `sync_2ff`, a parametrised-width 2-flop synchroniser with asynchronous reset. It is instantiated only under CAMERA_SYNC_EN.

## Test plan
All scenarios use defaults (CODE_W=3, STABLE_CYCLES=4, RELEASE_CYCLES=3) and no CAMERA_SYNC_EN.
- Clean lock: hold 3'd2 for 4 cycles. Required: new_product pulses once on the 4th edge; then product_detected=2, product_valid=1.
- Glitch reject: sequence 2,2,2,5,5,5,5. Required: no lock on 2; lock on 5 at the 4th 5-sample; new_product pulses once.
- Release: after locking 3, drive 0 for 2 cycles, then 3, then 0 for 3 cycles. Required: no release after the first 0 burst; product_removed pulses on the 3rd edge of the second burst; product_detected=0.
- Swap: lock 1, then drive 6 continuously. Required: release after 3 samples; new_product for 6 exactly STABLE_CYCLES samples after release, counted from IDLE.
- Reset mid-lock: assert reset asynchronously while 4 is locked. Required: all outputs 0 immediately, no product_removed pulse; after deassertion, re-lock takes a full 4 samples.
- CAMERA_SYNC_EN build: repeat the clean-lock scenario. Required: new_product arrives 2 cycles later than in the unsynchronised build.

Source files
------------

// File: rtl/camera_product_filter_pkg.sv
// Shared constants for the camera product filter and the scale controller:
// FSM state encoding and the "no product" code.
package camera_product_filter_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CANDIDATE = 2'd1,
    LOCKED    = 2'd2
  } state_t;

  localparam int NO_PRODUCT = 0;

endpackage

// File: rtl/camera_product_filter_sync_2ff.sv
// Parametrised-width two-flop synchroniser with asynchronous active-high reset.
// Both stages reset to zero so the filter sees "no product" out of reset.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/camera_product_filter.sv
// Debounces the raw camera product code: lock after STABLE_CYCLES identical
// samples, release after RELEASE_CYCLES non-matching ones. Define
// CAMERA_SYNC_EN to insert a 2-flop synchroniser on camera_output.
module camera_product_filter
  import camera_product_filter_pkg::*;
#(
  parameter int CODE_W         = 3,
  parameter int STABLE_CYCLES  = 4,
  parameter int RELEASE_CYCLES = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CODE_W-1:0] camera_output,
  output logic [CODE_W-1:0] product_detected,
  output logic              product_valid,
  output logic              new_product,
  output logic              product_removed
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int RW = $clog2(RELEASE_CYCLES + 1);
  localparam logic [SW-1:0]     STAB_LAST = SW'(STABLE_CYCLES);
  localparam logic [RW-1:0]     REL_LAST  = RW'(RELEASE_CYCLES);
  localparam logic [CODE_W-1:0] NONE      = CODE_W'(NO_PRODUCT);

  logic [CODE_W-1:0] code;

`ifdef CAMERA_SYNC_EN
  sync_2ff #(.W(CODE_W)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (camera_output),
    .q     (code)
  );
`else
  assign code = camera_output;
`endif

  state_t            state, state_nx;
  logic [CODE_W-1:0] cand, cand_nx, det_nx;
  logic [SW-1:0]     stab_cnt, stab_nx;
  logic [RW-1:0]     rel_cnt, rel_nx;
  logic              valid_nx, new_nx, rem_nx;

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case
    // leaves one unassigned, which would otherwise infer a latch.
    state_nx = state;
    cand_nx  = cand;
    stab_nx  = stab_cnt;
    rel_nx   = rel_cnt;
    det_nx   = product_detected;
    valid_nx = product_valid;
    new_nx   = 1'b0;
    rem_nx   = 1'b0;

    unique case (state)
      IDLE: begin
        if (code != NONE) begin
          cand_nx = code;
          if (STABLE_CYCLES == 1) begin
            state_nx = LOCKED;
            stab_nx  = STAB_LAST;
            det_nx   = code;
            valid_nx = 1'b1;
            new_nx   = 1'b1;
            rel_nx   = '0;
          end else begin
            state_nx = CANDIDATE;
            stab_nx  = SW'(1);
          end
        end
      end

      CANDIDATE: begin
        if (code == NONE) begin
          state_nx = IDLE;
          cand_nx  = NONE;
          stab_nx  = '0;
        end else if (code != cand) begin
          cand_nx = code;
          stab_nx = SW'(1);
        end else if (stab_cnt + SW'(1) >= STAB_LAST) begin
          // Counter saturates at its terminal value on entry to LOCKED.
          state_nx = LOCKED;
          stab_nx  = STAB_LAST;
          det_nx   = cand;
          valid_nx = 1'b1;
          new_nx   = 1'b1;
          rel_nx   = '0;
        end else begin
          stab_nx = stab_cnt + SW'(1);
        end
      end

      LOCKED: begin
        // A different code only counts towards release; it never swaps the lock.
        if (code == product_detected) begin
          rel_nx = '0;
        end else if (rel_cnt + RW'(1) >= REL_LAST) begin
          state_nx = IDLE;
          cand_nx  = NONE;
          stab_nx  = '0;
          rel_nx   = '0;
          det_nx   = NONE;
          valid_nx = 1'b0;
          rem_nx   = 1'b1;
        end else begin
          rel_nx = rel_cnt + RW'(1);
        end
      end

      default: begin
        state_nx = IDLE;
        cand_nx  = NONE;
        stab_nx  = '0;
        rel_nx   = '0;
        det_nx   = NONE;
        valid_nx = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      cand             <= '0;
      stab_cnt         <= '0;
      rel_cnt          <= '0;
      product_detected <= '0;
      product_valid    <= 1'b0;
      new_product      <= 1'b0;
      product_removed  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from the
      // same pre-edge values, independent of statement order.
      state            <= state_nx;
      cand             <= cand_nx;
      stab_cnt         <= stab_nx;
      rel_cnt          <= rel_nx;
      product_detected <= det_nx;
      product_valid    <= valid_nx;
      new_product      <= new_nx;
      product_removed  <= rem_nx;
    end
  end

endmodule

// File: tb/tb_camera_product_filter.sv
// Directed, table-driven bench for camera_product_filter at default parameters.
// With CAMERA_SYNC_EN defined it runs the clean-lock/release sequence shifted by 2.
module tb_camera_product_filter;

  typedef struct {
    logic [2:0] cam;
    logic [2:0] det;
    logic       valid;
    logic       newp;
    logic       rem;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] camera_output;
  logic [2:0] product_detected;
  logic       product_valid;
  logic       new_product;
  logic       product_removed;

  int total = 0;
  int bad   = 0;

  vec_t vecs[$];

  camera_product_filter dut (
    .clk              (clk),
    .reset            (reset),
    .camera_output    (camera_output),
    .product_detected (product_detected),
    .product_valid    (product_valid),
    .new_product      (new_product),
    .product_removed  (product_removed)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic [2:0] cam, logic [2:0] det, logic valid,
                              logic newp, logic rem);
    vec_t v;
    v.cam = cam; v.det = det; v.valid = valid; v.newp = newp; v.rem = rem;
    return v;
  endfunction

  task automatic check(string name, logic [2:0] det, logic valid, logic newp, logic rem);
    total++;
    if ({product_detected, product_valid, new_product, product_removed} !== {det, valid, newp, rem}) begin
      bad++;
      $display("FAIL %s: got det=%0d valid=%0b new=%0b rem=%0b, want det=%0d valid=%0b new=%0b rem=%0b",
               name, product_detected, product_valid, new_product, product_removed,
               det, valid, newp, rem);
    end
  endtask

  // Drive a sample, clock it in, look at the registered outputs 1 time unit later.
  task automatic step(logic [2:0] cam);
    camera_output = cam;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset         = 1'b1;
    camera_output = 3'd0;
    #12;
    check("reset_state", 3'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    #1;

`ifndef CAMERA_SYNC_EN
    // Clean lock on 2, hold, then release with three 0 samples.
    vecs.push_back(mk(3'd2, 3'd0, 0, 0, 0));
    vecs.push_back(mk(3'd2, 3'd0, 0, 0, 0));
    vecs.push_back(mk(3'd2, 3'd0, 0, 0, 0));
    vecs.push_back(mk(3'd2, 3'd2, 1, 1, 0));
    vecs.push_back(mk(3'd2, 3'd2, 1, 0, 0));
    vecs.push_back(mk(3'd0, 3'd2, 1, 0, 0));
    vecs.push_back(mk(3'd0, 3'd2, 1, 0, 0));
    vecs.push_back(mk(3'd0, 3'd0, 0, 0, 1));
    vecs.push_back(mk(3'd0, 3'd0, 0, 0, 0));
    // Glitch reject: 2,2,2 then 5 x4 locks on 5 only.
    vecs.push_back(mk(3'd2, 3'd0, 0, 0, 0));
    vecs.push_back(mk(3'd2, 3'd0, 0, 0, 0));
    vecs.push_back(mk(3'd2, 3'd0, 0, 0, 0));
    vecs.push_back(mk(3'd5, 3'd0, 0, 0, 0));
    vecs.push_back(mk(3'd5, 3'd0, 0, 0, 0));
    vecs.push_back(mk(3'd5, 3'd0, 0, 0, 0));
    vecs.push_back(mk(3'd5, 3'd5, 1, 1, 0));
    vecs.push_back(mk(3'd5, 3'd5, 1, 0, 0));
    vecs.push_back(mk(3'd0, 3'd5, 1, 0, 0));
    vecs.push_back(mk(3'd0, 3'd5, 1, 0, 0));
    vecs.push_back(mk(3'd0, 3'd0, 0, 0, 1));
    // Release counter cleared by a matching sample mid-burst.
    vecs.push_back(mk(3'd3, 3'd0, 0, 0, 0));
    vecs.push_back(mk(3'd3, 3'd0, 0, 0, 0));
    vecs.push_back(mk(3'd3, 3'd0, 0, 0, 0));
    vecs.push_back(mk(3'd3, 3'd3, 1, 1, 0));
    vecs.push_back(mk(3'd0, 3'd3, 1, 0, 0));
    vecs.push_back(mk(3'd0, 3'd3, 1, 0, 0));
    vecs.push_back(mk(3'd3, 3'd3, 1, 0, 0));
    vecs.push_back(mk(3'd0, 3'd3, 1, 0, 0));
    vecs.push_back(mk(3'd0, 3'd3, 1, 0, 0));
    vecs.push_back(mk(3'd0, 3'd0, 0, 0, 1));
    // Swap: lock 1, then 6 forever: release, then requalify from IDLE.
    vecs.push_back(mk(3'd1, 3'd0, 0, 0, 0));
    vecs.push_back(mk(3'd1, 3'd0, 0, 0, 0));
    vecs.push_back(mk(3'd1, 3'd0, 0, 0, 0));
    vecs.push_back(mk(3'd1, 3'd1, 1, 1, 0));
    vecs.push_back(mk(3'd6, 3'd1, 1, 0, 0));
    vecs.push_back(mk(3'd6, 3'd1, 1, 0, 0));
    vecs.push_back(mk(3'd6, 3'd0, 0, 0, 1));
    vecs.push_back(mk(3'd6, 3'd0, 0, 0, 0));
    vecs.push_back(mk(3'd6, 3'd0, 0, 0, 0));
    vecs.push_back(mk(3'd6, 3'd0, 0, 0, 0));
    vecs.push_back(mk(3'd6, 3'd6, 1, 1, 0));
    vecs.push_back(mk(3'd6, 3'd6, 1, 0, 0));
    vecs.push_back(mk(3'd0, 3'd6, 1, 0, 0));
    vecs.push_back(mk(3'd0, 3'd6, 1, 0, 0));
    vecs.push_back(mk(3'd0, 3'd0, 0, 0, 1));
    // Zero during qualification aborts to IDLE; then lock 4.
    vecs.push_back(mk(3'd4, 3'd0, 0, 0, 0));
    vecs.push_back(mk(3'd4, 3'd0, 0, 0, 0));
    vecs.push_back(mk(3'd0, 3'd0, 0, 0, 0));
    vecs.push_back(mk(3'd4, 3'd0, 0, 0, 0));
    vecs.push_back(mk(3'd4, 3'd0, 0, 0, 0));
    vecs.push_back(mk(3'd4, 3'd0, 0, 0, 0));
    vecs.push_back(mk(3'd4, 3'd4, 1, 1, 0));
    vecs.push_back(mk(3'd4, 3'd4, 1, 0, 0));

    foreach (vecs[i]) begin
      step(vecs[i].cam);
      check($sformatf("vec%0d", i), vecs[i].det, vecs[i].valid, vecs[i].newp, vecs[i].rem);
    end

    // Asynchronous reset while 4 is locked, away from any clock edge.
    #3;
    reset = 1'b1;
    #1;
    check("rst_async", 3'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("rst_hold", 3'd0, 1'b0, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(3'd4);
      check($sformatf("relock_wait%0d", i), 3'd0, 1'b0, 1'b0, 1'b0);
    end
    step(3'd4);
    check("relock", 3'd4, 1'b1, 1'b1, 1'b0);
`else
    // Synchronised build: lock and release each arrive 2 edges later.
    for (int i = 0; i < 5; i++) begin
      step(3'd2);
      check($sformatf("sync_wait%0d", i), 3'd0, 1'b0, 1'b0, 1'b0);
    end
    step(3'd2);
    check("sync_lock", 3'd2, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(3'd0);
      check($sformatf("sync_hold%0d", i), 3'd2, 1'b1, 1'b0, 1'b0);
    end
    step(3'd0);
    check("sync_release", 3'd0, 1'b0, 1'b0, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
